fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter AWIDTH, default 5, SHALL set the instruction/data address width.
REQ-002 Parameter DWIDTH, default 8, SHALL set the memory data width; opcode = data[DWIDTH-1:DWIDTH-3].
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 start  input  1  SHALL be the run request, sampled on clk.
REQ-006 data  input  DWIDTH  SHALL be the memory read bus, captured into IR.
REQ-007 sel  input  1  SHALL be the controller's address-select strobe (1 = PC, 0 = IR operand).
REQ-008 ld_ir, inc_pc, ld_pc, halt  input  1 each  SHALL be the controller strobes of the same names.
REQ-009 phase  output  3  SHALL be the current instruction phase (0..7) driven to the controller.
REQ-010 opcode  output  3  SHALL be IR[DWIDTH-1:DWIDTH-3].
REQ-011 ir_addr  output  AWIDTH  SHALL be IR[AWIDTH-1:0].
REQ-012 pc_addr  output  AWIDTH  SHALL be the program counter.
REQ-013 addr  output  AWIDTH  SHALL be pc_addr when sel=1, else ir_addr (combinational).
REQ-014 running, halted  output  1 each  SHALL reflect state RUN and HALTED respectively.

Function
REQ-015 The state machine SHALL have states IDLE, RUN, HALTED.
REQ-016 IDLE: start=1 SHALL move to RUN with phase held at 0; otherwise stay; all strobes ignored.
REQ-017 RUN: phase SHALL increment by 1 each cycle, wrapping 7 -> 0.
REQ-018 RUN: ld_ir=1 SHALL load IR from data on that edge; repeated loads in phases 2 and 3 SHALL be harmless.
REQ-019 RUN: inc_pc=1 SHALL increment PC modulo 2^AWIDTH (31 -> 0 at default).
REQ-020 RUN: ld_pc=1 SHALL load PC from ir_addr; when ld_pc and inc_pc are both high, ld_pc SHALL win.
REQ-021 RUN: halt=1 SHALL move to HALTED on that edge; inc_pc/ld_pc/ld_ir on the same edge SHALL still be honoured; phase SHALL NOT advance (holds its value).
REQ-022 HALTED: phase, PC, IR SHALL be frozen; ld_ir, inc_pc, ld_pc, halt SHALL be ignored.
REQ-023 HALTED: start=1 SHALL return to RUN, with phase advancing by 1 on the next edge (resume after halting instruction).
REQ-024 start while already in RUN SHALL have no effect.
REQ-025 Outputs opcode, ir_addr, pc_addr, phase SHALL be registered values (zero combinational latency from registers); strobes take effect one edge after assertion.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, phase=0, PC=0, IR=0, running=0, halted=0, regardless of clk.
REQ-027 Reset asserted mid-instruction SHALL discard the instruction; after release the block waits in IDLE for start.

Structure
REQ-028 Opcode constants (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7), state encoding and default widths SHALL live in shared package veririsc_pkg.
REQ-029 PC and phase counter SHALL each be an instance of sub-module counter (loadable, enabled, wrapping, width-parameterised, async active-high reset).
REQ-030 The addr mux and state machine SHALL be in fetch_sequencer itself.

Verification
REQ-031 rst pulse mid-RUN at phase 5 -> phase=0, pc_addr=0, opcode=0, running=0 within the same time step, before the next edge.
REQ-032 start, data=8'hA3 with ld_ir at phases 2-3, inc_pc at phase 4 -> opcode=5 (LDA), ir_addr=3, pc_addr=1; phase sequence 0..7,0.
REQ-033 PC=31 with inc_pc -> pc_addr=0 (wrap); phase 7 -> 0 (wrap).
REQ-034 IR=8'hE9 (JMP 9), ld_pc and inc_pc together -> pc_addr=9.
REQ-035 halt with inc_pc at phase 4, PC=6 -> halted=1, pc_addr=7, phase stays 4 for 10 cycles despite strobes; start -> phase=5 next edge, running=1.
REQ-036 sel toggled 1/0 with pc_addr=7, ir_addr=3 -> addr=7 then 3 with no clock edge.

Source files
------------

// File: rtl/veririsc_pkg.sv
// -----------------------------------------------------------------------------
// veririsc_pkg
// Shared definitions for the VeriRISC fetch/sequencing logic:
//   - default address / data widths
//   - phase counter width and opcode field width
//   - opcode constants (HLT..JMP)
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package veririsc_pkg;

    localparam int DEF_AWIDTH = 5;
    localparam int DEF_DWIDTH = 8;
    localparam int PHASE_W    = 3;
    localparam int OPCODE_W   = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the controller-facing signals of fetch_sequencer.
//   Controller -> sequencer : start, data, sel, ld_ir, inc_pc, ld_pc, halt
//   Sequencer -> controller : phase, opcode, ir_addr, pc_addr, addr,
//                             running, halted
// Modports: master = controller / stimulus side, slave = fetch_sequencer.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if
    import veririsc_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
);
    logic                start;
    logic [DWIDTH-1:0]   data;
    logic                sel;
    logic                ld_ir;
    logic                inc_pc;
    logic                ld_pc;
    logic                halt;

    logic [PHASE_W-1:0]  phase;
    logic [OPCODE_W-1:0] opcode;
    logic [AWIDTH-1:0]   ir_addr;
    logic [AWIDTH-1:0]   pc_addr;
    logic [AWIDTH-1:0]   addr;
    logic                running;
    logic                halted;

    modport master (
        output start, data, sel, ld_ir, inc_pc, ld_pc, halt,
        input  phase, opcode, ir_addr, pc_addr, addr, running, halted
    );

    modport slave (
        input  start, data, sel, ld_ir, inc_pc, ld_pc, halt,
        output phase, opcode, ir_addr, pc_addr, addr, running, halted
    );

endinterface

// File: rtl/fetch_sequencer_counter.sv
// -----------------------------------------------------------------------------
// counter
// Loadable, enabled, wrapping up-counter used for both the program counter
// and the instruction phase counter.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset, clears the count
//   i_en       : increment by one (wraps modulo 2^WIDTH)
//   i_load     : load i_load_val; takes priority over i_en
//   i_load_val : value to load
//   o_count    : registered count
// -----------------------------------------------------------------------------
module counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch / sequencing block: holds IR, PC and the 8-phase
// instruction counter, and runs the IDLE / RUN / HALTED state machine.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset (IDLE, phase=0, PC=0, IR=0)
//   bus : fetch_sequencer_if.slave
//         in : start, data, sel, ld_ir, inc_pc, ld_pc, halt
//         out: phase, opcode, ir_addr, pc_addr, addr, running, halted
// AWIDTH / DWIDTH must match the parameters of the connected interface.
// -----------------------------------------------------------------------------
module fetch_sequencer
    import veririsc_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.slave    bus
);

    seq_state_t          r_state;
    seq_state_t          w_state_next;

    logic [DWIDTH-1:0]   r_ir;
    logic [AWIDTH-1:0]   w_pc;
    logic [PHASE_W-1:0]  w_phase;

    logic                w_running;
    logic                w_halted;
    logic                w_phase_en;
    logic                w_pc_inc;
    logic                w_pc_load;
    logic                w_ir_load;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.start) w_state_next = ST_RUN;
            ST_RUN:    if (bus.halt)  w_state_next = ST_HALTED;
            ST_HALTED: if (bus.start) w_state_next = ST_RUN;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Output / strobe-qualification logic. Strobes only act in RUN; the
    // halting edge still honours the data-path strobes but freezes the
    // phase so the instruction resumes at the following phase.
    always_comb begin
        w_running  = 1'b0;
        w_halted   = 1'b0;
        w_phase_en = 1'b0;
        w_pc_inc   = 1'b0;
        w_pc_load  = 1'b0;
        w_ir_load  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_running  = 1'b1;
                w_phase_en = ~bus.halt;
                w_pc_inc   = bus.inc_pc;
                w_pc_load  = bus.ld_pc;
                w_ir_load  = bus.ld_ir;
            end
            ST_HALTED: begin
                w_halted   = 1'b1;
            end
            default: begin
                w_running  = 1'b0;
            end
        endcase
    end

    // Instruction register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir <= '0;
        end else if (w_ir_load) begin
            r_ir <= bus.data;
        end
    end

    // Phase counter: never loaded, only reset returns it to zero.
    counter #(.WIDTH(PHASE_W)) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_phase_en),
        .i_load     (1'b0),
        .i_load_val ({PHASE_W{1'b0}}),
        .o_count    (w_phase)
    );

    // Program counter: load (jump target from IR) beats increment.
    counter #(.WIDTH(AWIDTH)) u_pc_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_pc_inc),
        .i_load     (w_pc_load),
        .i_load_val (r_ir[AWIDTH-1:0]),
        .o_count    (w_pc)
    );

    assign bus.phase   = w_phase;
    assign bus.opcode  = r_ir[DWIDTH-1 -: OPCODE_W];
    assign bus.ir_addr = r_ir[AWIDTH-1:0];
    assign bus.pc_addr = w_pc;
    assign bus.addr    = bus.sel ? w_pc : r_ir[AWIDTH-1:0];
    assign bus.running = w_running;
    assign bus.halted  = w_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed self-checking bench for fetch_sequencer. Expected values go into a
// scoreboard queue when the stimulus is applied and are popped and compared
// once the design has produced the corresponding output.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

    fetch_sequencer #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  ph    = 0;

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty: observed %0d required <queued entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.exp);
            end
            $display("check %-14s observed %0d required %0d", e.tag, obs, e.exp);
        end
    endtask

    // Immediate check of a value that is already settled.
    task automatic chk(input string tag, input logic [31:0] exp, input logic [31:0] obs);
        sb_push(tag, exp);
        sb_check(obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One RUN-mode cycle with the given strobes; expected phase is queued
    // before the edge and compared after it.
    task automatic run_cyc(input logic li, input logic ip, input logic lp,
                           input logic hl, input string tag);
        bus.ld_ir  = li;
        bus.inc_pc = ip;
        bus.ld_pc  = lp;
        bus.halt   = hl;
        if (!hl) ph = (ph + 1) % 8;
        sb_push(tag, ph);
        tick();
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.halt   = 1'b0;
        sb_check(bus.phase);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.data   = 8'h00;
        bus.sel    = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.halt   = 1'b0;

        // Reset state, before any clock edge
        #2;
        chk("rst_phase",   0, bus.phase);
        chk("rst_pc",      0, bus.pc_addr);
        chk("rst_opcode",  0, bus.opcode);
        chk("rst_running", 0, bus.running);
        chk("rst_halted",  0, bus.halted);
        tick();
        tick();
        rst = 1'b0;

        // IDLE ignores strobes
        bus.data   = 8'hFF;
        bus.ld_ir  = 1'b1;
        bus.inc_pc = 1'b1;
        bus.ld_pc  = 1'b1;
        bus.halt   = 1'b1;
        tick();
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.halt   = 1'b0;
        chk("idle_pc",      0, bus.pc_addr);
        chk("idle_opcode",  0, bus.opcode);
        chk("idle_running", 0, bus.running);
        chk("idle_phase",   0, bus.phase);

        // Start, fetch LDA 3 (A3) with ld_ir at phases 2-3, inc_pc at 4
        bus.data  = 8'hA3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ph = 0;
        chk("start_running", 1, bus.running);
        chk("start_phase",   0, bus.phase);
        for (int i = 0; i < 8; i++) begin
            bus.start = (ph >= 5);   // start while running must be ignored
            run_cyc(ph == 2 || ph == 3, ph == 4, 1'b0, 1'b0, "fetch_phase");
        end
        bus.start = 1'b0;
        chk("lda_opcode",  5, bus.opcode);
        chk("lda_iraddr",  3, bus.ir_addr);
        chk("lda_pc",      1, bus.pc_addr);
        chk("run_running", 1, bus.running);

        // Asynchronous reset mid-RUN at phase 5
        for (int i = 0; i < 5; i++) run_cyc(1'b0, 1'b0, 1'b0, 1'b0, "pre_rst_phase");
        rst = 1'b1;
        #1;
        chk("arst_phase",   0, bus.phase);
        chk("arst_pc",      0, bus.pc_addr);
        chk("arst_opcode",  0, bus.opcode);
        chk("arst_running", 0, bus.running);
        tick();
        rst = 1'b0;
        ph  = 0;
        tick();
        chk("post_rst_idle", 0, bus.running);
        chk("post_rst_ph",   0, bus.phase);

        // PC wrap 31 -> 0, phase wrap 7 -> 0
        bus.data  = 8'h1F;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        run_cyc(1'b1, 1'b0, 1'b0, 1'b0, "ld_ir_phase");
        chk("ir_31", 31, bus.ir_addr);
        run_cyc(1'b0, 1'b0, 1'b1, 1'b0, "ld_pc_phase");
        chk("pc_31", 31, bus.pc_addr);
        run_cyc(1'b0, 1'b1, 1'b0, 1'b0, "inc_phase");
        chk("pc_wrap", 0, bus.pc_addr);
        for (int i = 0; i < 4; i++) run_cyc(1'b0, 1'b0, 1'b0, 1'b0, "walk_phase");
        run_cyc(1'b0, 1'b0, 1'b0, 1'b0, "phase_wrap");

        // JMP 9: ld_pc beats inc_pc
        bus.data = 8'hE9;
        run_cyc(1'b1, 1'b0, 1'b0, 1'b0, "jmp_ir_phase");
        chk("jmp_opcode", 7, bus.opcode);
        chk("jmp_iraddr", 9, bus.ir_addr);
        run_cyc(1'b0, 1'b1, 1'b1, 1'b0, "jmp_pc_phase");
        chk("jmp_pc", 9, bus.pc_addr);

        // Halt with inc_pc at phase 4, PC=6
        bus.data = 8'h06;
        run_cyc(1'b1, 1'b0, 1'b0, 1'b0, "h_ir_phase");
        run_cyc(1'b0, 1'b0, 1'b1, 1'b0, "h_pc_phase");
        chk("h_pc6", 6, bus.pc_addr);
        run_cyc(1'b0, 1'b1, 1'b0, 1'b1, "halt_phase");
        chk("halt_halted",  1, bus.halted);
        chk("halt_running", 0, bus.running);
        chk("halt_pc",      7, bus.pc_addr);
        bus.data = 8'h55;
        for (int i = 0; i < 10; i++) begin
            run_cyc(1'b1, 1'b1, 1'b1, 1'b1, "frozen_phase");
            chk("frozen_pc",  7, bus.pc_addr);
            chk("frozen_op",  0, bus.opcode);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("resume_run",   1, bus.running);
        chk("resume_halt",  0, bus.halted);
        chk("resume_phase", 4, bus.phase);
        run_cyc(1'b0, 1'b0, 1'b0, 1'b0, "resume_next");

        // Address mux, no clock edge between sel changes
        bus.data = 8'hA3;
        run_cyc(1'b1, 1'b0, 1'b0, 1'b1, "mux_setup_ph");
        chk("mux_iraddr", 3, bus.ir_addr);
        chk("mux_pc",     7, bus.pc_addr);
        bus.sel = 1'b1;
        #1;
        chk("addr_sel1", 7, bus.addr);
        bus.sel = 1'b0;
        #1;
        chk("addr_sel0", 3, bus.addr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
